// File: rtl/immed_gen_pipe.sv
// Two-stage immediate generator: stage 1 decodes opcode into an extension mode, stage 2 forms immed.
// Latency: out_valid one edge after stage-1 capture; one result per cycle when unstalled.
// Backpressure: output holds while !out_ready; in_ready drops only when stage 1 is full and the output stalls.
module immed_gen_pipe #(
    parameter int DATA_W        = 32,
    parameter int IMM_W         = 16,
    parameter int TAG_W         = 4,
    parameter bit BRANCH_SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic [5:0]        opcode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] immed,
    output logic [TAG_W-1:0]  out_tag,
    output logic              op_err
);
    localparam int EXT_W = DATA_W - IMM_W;

    typedef enum logic [2:0] {
        MODE_NONE = 3'd0,
        MODE_SEXT = 3'd1,
        MODE_ZEXT = 3'd2,
        MODE_HI   = 3'd3,
        MODE_BR   = 3'd4
    } mode_t;

    logic              s1_valid;
    mode_t             s1_mode;
    logic [IMM_W-1:0]  s1_imm;
    logic [TAG_W-1:0]  s1_tag;

    mode_t             dec_mode;
    logic              out_adv;
    logic [DATA_W-1:0] sext_imm;
    logic [DATA_W-1:0] zext_imm;
    logic [DATA_W-1:0] res;
    logic              res_err;

    // Upper instruction bits carry no immediate information.
    logic instr_unused;
    assign instr_unused = ^instr[DATA_W-1:IMM_W];

    always_comb begin
        dec_mode = MODE_NONE;
        case (opcode)
            6'b111000, 6'b110000, 6'b000011,
            6'b000111, 6'b001111, 6'b011111: dec_mode = MODE_SEXT;
            6'b110010, 6'b110011:            dec_mode = MODE_ZEXT;
            6'b111001:                       dec_mode = MODE_HI;
            6'b111111, 6'b000000, 6'b000001: dec_mode = MODE_BR;
            default:                         dec_mode = MODE_NONE;
        endcase
    end

    assign out_adv  = !out_valid || out_ready;
    assign in_ready = !s1_valid || out_adv;

    assign sext_imm = {{EXT_W{s1_imm[IMM_W-1]}}, s1_imm};
    assign zext_imm = {{EXT_W{1'b0}}, s1_imm};

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        case (s1_mode)
            MODE_SEXT: res = sext_imm;
            MODE_ZEXT: res = zext_imm;
            MODE_HI:   res = {s1_imm, {EXT_W{1'b0}}};
            MODE_BR:   res = (BRANCH_SIGNED ? sext_imm : zext_imm) << 2;
            default:   res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_NONE;
            s1_imm   <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= dec_mode;
                s1_imm  <= instr[IMM_W-1:0];
                s1_tag  <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            immed     <= '0;
            out_tag   <= '0;
            op_err    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                immed   <= res;
                out_tag <= s1_tag;
                op_err  <= res_err;
            end
        end
    end

endmodule

// File: tb/tb_immed_gen_pipe.sv
// Bench for immed_gen_pipe: two instances (signed / unsigned branch) share stimulus;
// a queue-based reference model checks every output handshake and the in_ready rule.
module tb_immed_gen_pipe;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic [DW-1:0] instr;
    logic [5:0]    opcode;
    logic [TW-1:0] in_tag;
    logic          ir1, ov1, err1, ir0, ov0, err0;
    logic [DW-1:0] imm1, imm0;
    logic [TW-1:0] tag1, tag0;

    immed_gen_pipe #(.DATA_W(DW), .IMM_W(IW), .TAG_W(TW), .BRANCH_SIGNED(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .instr(instr), .opcode(opcode), .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready),
        .immed(imm1), .out_tag(tag1), .op_err(err1)
    );

    immed_gen_pipe #(.DATA_W(DW), .IMM_W(IW), .TAG_W(TW), .BRANCH_SIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .instr(instr), .opcode(opcode), .in_tag(in_tag), .out_valid(ov0), .out_ready(out_ready),
        .immed(imm0), .out_tag(tag0), .op_err(err0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [15:0] imm;
        logic [31:0] exp1;
        logic [31:0] exp0;
        logic        err;
    } vec_t;

    typedef struct {
        logic [5:0]  op;
        logic [15:0] imm;
        logic [3:0]  tag;
    } item_t;

    item_t       q[$];
    vec_t        vt[15];
    logic [5:0]  bp_op[3];
    logic [15:0] bp_imm[3];
    logic [5:0]  valid_ops[12];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Result per the opcode table, computed with plain integer arithmetic; bit 32 is op_err.
    function automatic logic [32:0] ref_out(input logic [5:0] op, input logic [15:0] imm, input bit bs);
        longint s, z, v;
        logic   err;
        s   = longint'($signed(imm));
        z   = longint'(imm);
        v   = 0;
        err = 1'b0;
        case (op)
            6'b111000, 6'b110000, 6'b000011, 6'b000111, 6'b001111, 6'b011111: v = s;
            6'b110010, 6'b110011: v = z;
            6'b111001:            v = z * 65536;
            6'b111111, 6'b000000, 6'b000001: v = (bs ? s : z) * 4;
            default:              err = 1'b1;
        endcase
        return {err, v[31:0]};
    endfunction

    task automatic drive(input bit v, input logic [5:0] op, input logic [15:0] imm, input logic [3:0] tag);
        in_valid = v;
        opcode   = op;
        instr    = {16'($urandom), imm};
        in_tag   = tag;
    endtask

    // Scoreboard: samples pre-edge values at the falling edge.
    task automatic monitor();
        logic [32:0] r1, r0;
        bit          held;
        bit          exp_ir;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                held = 1'b0;
            end else begin
                exp_ir = (q.size() < 2) || out_ready;
                check("in_ready_bs1", 32'(ir1), 32'(exp_ir));
                check("in_ready_bs0", 32'(ir0), 32'(exp_ir));
                if (q.size() == 2) begin
                    check("full_out_valid_bs1", 32'(ov1), 32'd1);
                    check("full_out_valid_bs0", 32'(ov0), 32'd1);
                end
                if (q.size() == 0) begin
                    check("empty_out_valid_bs1", 32'(ov1), 32'd0);
                    check("empty_out_valid_bs0", 32'(ov0), 32'd0);
                end
                if (held) check("stall_hold_valid", 32'(ov1), 32'd1);
                if (flush) begin
                    q.delete();
                    held = 1'b0;
                end else begin
                    if (ov1 && q.size() > 0) begin
                        r1 = ref_out(q[0].op, q[0].imm, 1'b1);
                        r0 = ref_out(q[0].op, q[0].imm, 1'b0);
                        check("sb_immed_bs1", imm1, r1[31:0]);
                        check("sb_err_bs1", 32'(err1), 32'(r1[32]));
                        check("sb_tag_bs1", 32'(tag1), 32'(q[0].tag));
                        check("sb_immed_bs0", imm0, r0[31:0]);
                        check("sb_err_bs0", 32'(err0), 32'(r0[32]));
                        check("sb_tag_bs0", 32'(tag0), 32'(q[0].tag));
                        if (out_ready) begin
                            q.delete(0);
                            n_out++;
                        end
                    end
                    if (in_valid && exp_ir)
                        q.push_back(item_t'{op: opcode, imm: instr[15:0], tag: in_tag});
                    held = ov1 && !out_ready;
                end
            end
        end
    endtask

    task automatic main_seq();
        int idx, k, out_before;
        logic acc;

        vt[0]  = '{6'b111000, 16'h8001, 32'hFFFF8001, 32'hFFFF8001, 1'b0};
        vt[1]  = '{6'b111001, 16'h1234, 32'h12340000, 32'h12340000, 1'b0};
        vt[2]  = '{6'b110010, 16'hFFFF, 32'h0000FFFF, 32'h0000FFFF, 1'b0};
        vt[3]  = '{6'b000000, 16'hFFFF, 32'hFFFFFFFC, 32'h0003FFFC, 1'b0};
        vt[4]  = '{6'b101010, 16'h7FFF, 32'h00000000, 32'h00000000, 1'b1};
        vt[5]  = '{6'b000011, 16'h7FFF, 32'h00007FFF, 32'h00007FFF, 1'b0};
        vt[6]  = '{6'b110011, 16'h8000, 32'h00008000, 32'h00008000, 1'b0};
        vt[7]  = '{6'b000001, 16'h8000, 32'hFFFE0000, 32'h00020000, 1'b0};
        vt[8]  = '{6'b111111, 16'h0001, 32'h00000004, 32'h00000004, 1'b0};
        vt[9]  = '{6'b011111, 16'hFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0};
        vt[10] = '{6'b000111, 16'h0000, 32'h00000000, 32'h00000000, 1'b0};
        vt[11] = '{6'b001111, 16'hABCD, 32'hFFFFABCD, 32'hFFFFABCD, 1'b0};
        vt[12] = '{6'b110000, 16'h1234, 32'h00001234, 32'h00001234, 1'b0};
        vt[13] = '{6'b111001, 16'hFFFF, 32'hFFFF0000, 32'hFFFF0000, 1'b0};
        vt[14] = '{6'b000010, 16'h1234, 32'h00000000, 32'h00000000, 1'b1};
        bp_op  = '{6'b000111, 6'b111001, 6'b000001};
        bp_imm = '{16'h9000, 16'h00AB, 16'h4000};
        valid_ops = '{6'b111000, 6'b110000, 6'b000011, 6'b000111, 6'b001111, 6'b011111,
                      6'b110010, 6'b110011, 6'b111001, 6'b111111, 6'b000000, 6'b000001};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 6'b0, 16'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(ov1), 32'd0);
        check("rst_immed", imm1, 32'd0);
        check("rst_out_tag", 32'(tag1), 32'd0);
        check("rst_op_err", 32'(err1), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", 32'(ir1), 32'd1);

        // First-transaction latency
        out_ready = 1'b1;
        drive(1'b1, 6'b111000, 16'h8001, 4'd3);
        @(posedge clk); #1;
        drive(1'b0, 6'b0, 16'h0, 4'h0);
        check("latency_not_early", 32'(ov1), 32'd0);
        @(posedge clk); #1;
        check("latency_out_valid", 32'(ov1), 32'd1);
        check("latency_immed", imm1, 32'hFFFF8001);
        check("latency_tag", 32'(tag1), 32'd3);
        check("latency_err", 32'(err1), 32'd0);
        @(posedge clk); #1;

        // Back-to-back table stream
        for (int i = 0; i <= 15; i++) begin
            if (i < 15) drive(1'b1, vt[i].op, vt[i].imm, 4'(i));
            else        drive(1'b0, 6'b0, 16'h0, 4'h0);
            @(posedge clk); #1;
            if (i >= 1) begin
                check("tbl_valid", 32'(ov1), 32'd1);
                check("tbl_immed_bs1", imm1, vt[i-1].exp1);
                check("tbl_immed_bs0", imm0, vt[i-1].exp0);
                check("tbl_err_bs1", 32'(err1), 32'(vt[i-1].err));
                check("tbl_err_bs0", 32'(err0), 32'(vt[i-1].err));
                check("tbl_tag", 32'(tag1), 32'(i-1));
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("tbl_drained", 32'(q.size()), 32'd0);

        // Backpressure: 5 stalled cycles, 3 offered, 2 accepted
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            k = (idx < 3) ? idx : 2;
            drive(1'b1, bp_op[k], bp_imm[k], 4'(5 + k));
            @(negedge clk);
            acc = ir1;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd2);
        out_before = n_out;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            drive(1'b1, bp_op[2], bp_imm[2], 4'd7);
            @(negedge clk);
            acc = ir1;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        drive(1'b0, 6'b0, 16'h0, 4'h0);
        repeat (4) @(posedge clk);
        #1;
        check("bp_emerged", 32'(n_out - out_before), 32'd3);
        check("bp_drained", 32'(q.size()), 32'd0);

        // Flush with both stages full
        out_ready = 1'b0;
        drive(1'b1, 6'b110011, 16'h1111, 4'd9);
        @(posedge clk); #1;
        drive(1'b1, 6'b110000, 16'h2222, 4'd10);
        @(posedge clk); #1;
        check("flush_pre_valid", 32'(ov1), 32'd1);
        flush = 1'b1;
        drive(1'b1, 6'b111000, 16'h3333, 4'd11);
        @(posedge clk); #1;
        flush = 1'b0;
        drive(1'b0, 6'b0, 16'h0, 4'h0);
        check("flush_out_valid_bs1", 32'(ov1), 32'd0);
        check("flush_out_valid_bs0", 32'(ov0), 32'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_no_leak", 32'(ov1), 32'd0);

        // Asynchronous reset mid-stream
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 6'b110010, 16'h7001 + 16'(c), 4'(c));
            @(posedge clk); #1;
        end
        check("arst_pre_valid", 32'(ov1), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid_bs1", 32'(ov1), 32'd0);
        check("arst_immed_bs1", imm1, 32'd0);
        check("arst_out_valid_bs0", 32'(ov0), 32'd0);
        check("arst_immed_bs0", imm0, 32'd0);
        drive(1'b0, 6'b0, 16'h0, 4'h0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_resume_idle", 32'(ov1), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0)
                drive($urandom_range(0, 3) != 0, 6'($urandom), 16'($urandom), 4'($urandom));
            else
                drive($urandom_range(0, 3) != 0, valid_ops[$urandom_range(0, 11)], 16'($urandom), 4'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 6'b0, 16'h0, 4'h0);
        repeat (4) @(posedge clk);
        #1;
        check("rand_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor();
            main_seq();
            begin
                #500000;
                n_err++;
                $display("FAIL timeout: bench did not complete within the time limit");
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/immed_gen_pipe.md
Name: immed_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the CPU datapath. It decodes the opcode into an extension mode and produces the extended or shifted immediate for the ALU and branch-target adder. The block has two pipeline stages with valid/ready handshakes on both sides, an instruction tag that travels alongside the data, a flush input, and an error flag for unsupported opcodes.

Parameters:
DATA_W, 32, output/instruction word width; must be >= IMM_W+2
IMM_W, 16, immediate field width, taken from instr[IMM_W-1:0]
TAG_W, 4, width of the sideband tag carried with each instruction
BRANCH_SIGNED, 1, 1: branch opcodes use sign-extend then shift-left-2; 0: zero-extend then shift-left-2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; invalidates both stages
in_valid  input  1  instr/opcode/in_tag valid
in_ready  output  1  block can accept input this cycle
instr  input  DATA_W  instruction word
opcode  input  6  instruction opcode
in_tag  input  TAG_W  sideband tag
out_valid  output  1  immed/out_tag/op_err valid
out_ready  input  1  consumer accepts output this cycle
immed  output  DATA_W  extended immediate
out_tag  output  TAG_W  tag of the instruction in immed
op_err  output  1  opcode not in the decode table; immed is 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: s1_valid=0, out_valid=0, immed=0, out_tag=0, op_err=0. in_ready=1 after reset is released.
- Decode table (stage 1), mode by opcode:
  111000, 110000, 000011, 000111, 001111, 011111 -> SEXT: imm sign-extended to DATA_W.
  110010, 110011 -> ZEXT: zero-extended.
  111001 -> HI: {imm, (DATA_W-IMM_W) zeros}.
  111111, 000000, 000001 -> BR: ({sext or zext per BRANCH_SIGNED}(imm)) << 2, truncated to DATA_W.
  Any other opcode -> NONE: result 0, op_err=1.
- Sign extension replicates instr[IMM_W-1] across all DATA_W-IMM_W upper bits. Partial replication is not allowed.
- Stage 1 registers the mode (3-bit encoding), imm and tag. Stage 2 (the output register) computes the result and registers immed, op_err and out_tag.
- Handshakes:
  - An input is accepted on an edge where in_valid && in_ready.
  - Output is consumed on an edge where out_valid && out_ready.
  - The output stage advances when !out_valid || out_ready.
  - in_ready = !s1_valid || stage-2 advance. in_ready is combinational from out_ready and internal state only, never from in_valid.
- Latency: an input accepted at edge k appears with out_valid=1 after edge k+1, provided there is no backpressure. Throughput is 1 per cycle.
- Stall: while out_valid && !out_ready, immed/out_tag/op_err stay stable, stage 1 holds, and in_ready=0 if s1_valid=1. No data is lost or duplicated.
- Simultaneous consume and accept: both happen on the same edge. Stage 1 moves to stage 2 and the new input moves into stage 1.
- flush: on an edge with flush=1, s1_valid and out_valid are cleared. Any input presented that cycle is dropped, and in_ready is still reported. Data registers may keep stale values. flush takes priority over all handshakes.
- Reset mid-operation: all valids clear immediately (asynchronously). In-flight instructions are discarded.
- The mode encoding is internal. Only immed, op_err and out_tag are observable.

Test Plan:
- Reset, then opcode=111000, instr[15:0]=0x8001, tag=3, out_ready=1 -> after 2 edges: out_valid=1, immed=0xFFFF8001, out_tag=3, op_err=0.
- Back-to-back stream: 111001/0x1234, 110010/0xFFFF, 000000/0xFFFF (BRANCH_SIGNED=1), one per cycle -> consecutive outputs 0x12340000, 0x0000FFFF, 0xFFFFFFFC in order. Repeat with BRANCH_SIGNED=0 -> third output 0x0003FFFC.
- Unknown opcode 101010 with imm 0x7FFF -> immed=0, op_err=1. The next valid opcode clears op_err.
- Backpressure: hold out_ready=0 for 5 cycles while driving 3 inputs -> exactly 2 accepted (in_ready drops), output stable throughout. On release, all accepted items emerge in order with no loss or duplication.
- flush asserted while both stages are valid -> out_valid=0 on the next cycle, and the flushed tags never appear at the output.
- Assert rst_n=0 asynchronously mid-stream -> out_valid and immed go to 0 before the next clk edge. Normal operation resumes after release.
